// File: rtl/dac_serial_out_pkg.sv
// -----------------------------------------------------------------------------
// dac_serial_out_pkg
// Shared constants and types for the serial DAC output stage.
//   FRAME_W     : bits per serial frame (control nibble + DAC code)
//   CODE_W      : DAC code width (offset binary)
//   CTRL_NIBBLE : control bits sent ahead of the code
//   state_t     : frame FSM state encoding
//   build_frame : assembles a full frame from a DAC code
// -----------------------------------------------------------------------------
package dac_serial_out_pkg;

  localparam int FRAME_W   = 16;
  localparam int CODE_W    = 12;
  localparam int BIT_CNT_W = 4;

  localparam logic [FRAME_W-CODE_W-1:0] CTRL_NIBBLE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [CODE_W-1:0] code);
    return {CTRL_NIBBLE, code};
  endfunction

endpackage

// File: rtl/dac_serial_out_if.sv
// -----------------------------------------------------------------------------
// dac_serial_out_if
// Bundle between the filter chain, the serial DAC stage and the DAC pins.
//   rx        : one-cycle strobe, y valid (filter's rx_2)
//   y         : signed fixed-point sample, cant_bits wide
//   sclk      : serial clock to DAC, idles high
//   sync_n    : frame enable, active low
//   din       : serial data, MSB first
//   busy      : frame in progress (shift or inter-frame gap)
//   done      : one-cycle pulse at end of each frame
//   overrun   : one-cycle pulse when an unsent pending sample is overwritten
//   dbg_state : current frame FSM state
// Modports: master = sample source / observer, slave = dac_serial_out.
//
// Handshake: rx is a valid-only strobe with no ready. The stage accepts y on
// every cycle rx is high; back-pressure is replaced by the one-deep pending
// buffer, and a sample that displaces an unsent one raises overrun.
// -----------------------------------------------------------------------------
interface dac_serial_out_if #(
  parameter int cant_bits = 25
);
  import dac_serial_out_pkg::*;

  logic                 rx;
  logic [cant_bits-1:0] y;
  logic                 sclk;
  logic                 sync_n;
  logic                 din;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  state_t               dbg_state;

  modport master (
    output rx, y,
    input  sclk, sync_n, din, busy, done, overrun, dbg_state
  );

  modport slave (
    input  rx, y,
    output sclk, sync_n, din, busy, done, overrun, dbg_state
  );

endinterface

// File: rtl/dac_serial_out_sat_conv.sv
// -----------------------------------------------------------------------------
// dac_serial_out_sat_conv
// Combinational conversion of a signed Q(cant_bits-frac_bits).frac_bits sample
// to a 12-bit offset-binary DAC code (+-1.0 maps to DAC full scale).
//   i_y    : signed input sample
//   o_code : offset-binary DAC code
// Build option DAC_SAT_EN: when defined, out-of-range samples clamp to the
// code rails; when undefined, the code is the low 12 bits (wraps).
// -----------------------------------------------------------------------------
module dac_serial_out_sat_conv
  import dac_serial_out_pkg::*;
#(
  parameter int cant_bits = 25,
  parameter int frac_bits = 15
) (
  input  logic signed [cant_bits-1:0] i_y,
  output logic        [CODE_W-1:0]    o_code
);

  // Keep CODE_W-1 fractional-equivalent bits so that 1.0 lands at 2048.
  localparam int SHR = frac_bits - (CODE_W - 1);

  logic signed [cant_bits-1:0] w_s;
  logic        [CODE_W-1:0]    w_s12;

  assign w_s = i_y >>> SHR;

`ifdef DAC_SAT_EN
  localparam logic signed [cant_bits-1:0] C_MAX = cant_bits'(2 ** (CODE_W - 1) - 1);
  localparam logic signed [cant_bits-1:0] C_MIN = cant_bits'(-(2 ** (CODE_W - 1)));

  always_comb begin
    w_s12 = w_s[CODE_W-1:0];
    if (w_s > C_MAX) begin
      w_s12 = {1'b0, {(CODE_W-1){1'b1}}};
    end else if (w_s < C_MIN) begin
      w_s12 = {1'b1, {(CODE_W-1){1'b0}}};
    end
  end
`else
  // Upper bits are discarded on purpose: the code simply wraps.
  logic w_unused_hi;
  assign w_unused_hi = ^w_s[cant_bits-1:CODE_W];
  assign w_s12       = w_s[CODE_W-1:0];
`endif

  // Adding 2048 to a 12-bit two's complement value is an MSB flip.
  assign o_code = {~w_s12[CODE_W-1], w_s12[CODE_W-2:0]};

endmodule

// File: rtl/dac_serial_out.sv
// -----------------------------------------------------------------------------
// dac_serial_out
// Captures filtered samples on rx, converts them to offset-binary DAC codes and
// shifts 16-bit frames (control nibble + code, MSB first) out on a 3-wire DAC
// link. A one-deep pending buffer decouples sample rate from frame time.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   dac : dac_serial_out_if.slave (rx/y in; sclk/sync_n/din/busy/done/overrun/
//         dbg_state out)
// Parameters: cant_bits (sample width), frac_bits (fraction bits),
//   clk_div (sclk half-period in clk cycles, >= 1).
// Build option DAC_SAT_EN: enables saturation in the converter.
// All link outputs are registered so the DAC pins never glitch.
// -----------------------------------------------------------------------------
module dac_serial_out
  import dac_serial_out_pkg::*;
#(
  parameter int cant_bits = 25,
  parameter int frac_bits = 15,
  parameter int clk_div   = 2
) (
  input logic             clk,
  input logic             rst,
  dac_serial_out_if.slave dac
);

  // Phase counter spans one full bit (sclk high then low); the gap reuses it.
  localparam int PH_MAX = 2 * clk_div - 1;
  localparam int PH_W   = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] C_PH_BIT_END = PH_W'(PH_MAX);
  localparam logic [PH_W-1:0] C_PH_GAP_END = PH_W'(clk_div - 1);
  localparam logic [PH_W-1:0] C_PH_HIGH    = PH_W'(clk_div);

  state_t                 r_state, w_state_nxt;
  logic [PH_W-1:0]        r_phase, w_phase_nxt;
  logic [BIT_CNT_W-1:0]   r_bit, w_bit_nxt;
  logic [FRAME_W-1:0]     r_shift, w_shift_nxt;
  logic                   r_pend_valid;
  logic [CODE_W-1:0]      r_pend_code;
  logic                   w_load;
  logic                   w_done_nxt;
  logic                   w_in_shift;
  logic [CODE_W-1:0]      w_code;

  logic r_sclk, r_sync_n, r_din, r_busy, r_done, r_overrun;

  dac_serial_out_sat_conv #(
    .cant_bits (cant_bits),
    .frac_bits (frac_bits)
  ) u_sat_conv (
    .i_y    (dac.y),
    .o_code (w_code)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM: next state, counters and shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_pend_valid) begin
          w_load = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (r_phase == C_PH_BIT_END) begin
          w_phase_nxt = '0;
          if (r_bit == '0) begin
            w_state_nxt = ST_GAP;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_nxt   = r_bit - 1'b1;
            w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end

      ST_GAP: begin
        if (r_phase == C_PH_GAP_END) begin
          w_phase_nxt = '0;
          if (r_pend_valid) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
      end
    endcase

    // Loading the pending sample always starts a fresh frame at bit 15.
    if (w_load) begin
      w_state_nxt = ST_SHIFT;
      w_phase_nxt = '0;
      w_bit_nxt   = BIT_CNT_W'(FRAME_W - 1);
      w_shift_nxt = build_frame(r_pend_code);
    end
  end

  assign w_in_shift = (w_state_nxt == ST_SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending buffer: a new sample always wins; it only counts as an overrun
  // when the old one was not taken by a frame load in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid <= 1'b0;
      r_pend_code  <= '0;
    end else if (dac.rx) begin
      r_pend_valid <= 1'b1;
      r_pend_code  <= w_code;
    end else if (w_load) begin
      r_pend_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered link outputs, derived from the next-cycle FSM view.
  // sclk is high for the first clk_div cycles of each bit, so din only ever
  // changes together with a rising (or idle-high) sclk.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk    <= 1'b1;
      r_sync_n  <= 1'b1;
      r_din     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sclk    <= !w_in_shift || (w_phase_nxt < C_PH_HIGH);
      r_sync_n  <= !w_in_shift;
      r_din     <= w_in_shift && w_shift_nxt[FRAME_W-1];
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      r_overrun <= dac.rx && r_pend_valid && !w_load;
    end
  end

  assign dac.sclk      = r_sclk;
  assign dac.sync_n    = r_sync_n;
  assign dac.din       = r_din;
  assign dac.busy      = r_busy;
  assign dac.done      = r_done;
  assign dac.overrun   = r_overrun;
  assign dac.dbg_state = r_state;

endmodule

// File: tb/tb_dac_serial_out.sv
// -----------------------------------------------------------------------------
// tb_dac_serial_out
// Self-checking bench for dac_serial_out: a frame-time model predicts every
// output on every cycle, a decoder rebuilds frames from sclk falling edges and
// scores them against an expected queue, and directed cases pin literal codes.
// -----------------------------------------------------------------------------
module tb_dac_serial_out;
  import dac_serial_out_pkg::*;

  localparam int D     = 2;
  localparam int CB    = 25;
  localparam int FB    = 15;
  localparam int SCALE = 1 << (FB - 11);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dac_serial_out_if #(.cant_bits(CB)) dac();

  dac_serial_out #(
    .cant_bits (CB),
    .frac_bits (FB),
    .clk_div   (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dac (dac)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] ref_code(input logic [CB-1:0] v);
    int yi, s, c;
    yi = int'($signed(v));
    if (yi < 0) s = -((-yi + SCALE - 1) / SCALE);
    else        s = yi / SCALE;
`ifdef DAC_SAT_EN
    if (s > 2047)  s = 2047;
    if (s < -2048) s = -2048;
`endif
    c = ((s + 2048) % 4096 + 4096) % 4096;
    return c[11:0];
  endfunction

  // Frame timeline: t counts cycles since the frame load; 32*D shift cycles
  // then D gap cycles.
  bit          m_active = 0;
  int          m_t = 0;
  logic [15:0] m_frame = '0;
  bit          m_pend_v = 0;
  logic [11:0] m_pend_code = '0;
  bit          m_ov = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_t = 0; m_pend_v = 0; m_ov = 0;
      exp_q.delete();
    end else begin
      bit eof, load;
      eof  = m_active && (m_t == 33 * D - 1);
      load = m_pend_v && (!m_active || eof);
      m_ov = dac.rx && m_pend_v && !load;
      if (load) begin
        m_frame  = {4'h0, m_pend_code};
        exp_q.push_back(m_frame);
        m_active = 1;
        m_t      = 0;
      end else if (eof) begin
        m_active = 0;
      end else if (m_active) begin
        m_t++;
      end
      if (dac.rx) begin
        m_pend_v    = 1;
        m_pend_code = ref_code(dac.y);
      end else if (load) begin
        m_pend_v = 0;
      end
    end
  end

  // ---------------- compare + frame decoder (negedge) ----------------
  bit          prev_sync = 1, prev_sclk = 1;
  int          bit_cnt = 0, frame_cnt = 0, done_cnt = 0, ov_cnt = 0;
  int          fall_cyc = 0, rise_cyc = 0, low_len = 0, gap_len = 0;
  logic [15:0] shreg = '0, last_frame = '0;

  always @(negedge clk) begin
    if (rst) begin
      logic [5:0] e, g;
      if (m_active) begin
        if (m_t < 32 * D)
          e = {((m_t % (2 * D)) < D), 1'b0, m_frame[15 - m_t / (2 * D)], 1'b1, 1'b0, m_ov};
        else
          e = {1'b1, 1'b1, 1'b0, 1'b1, (m_t == 32 * D), m_ov};
      end else begin
        e = {5'b11000, m_ov};
      end
      g = {dac.sclk, dac.sync_n, dac.din, dac.busy, dac.done, dac.overrun};
      check("outputs{sclk,sync_n,din,busy,done,ovr}", {26'd0, g}, {26'd0, e});

      if (prev_sync && !dac.sync_n) begin
        fall_cyc = cyc; gap_len = cyc - rise_cyc; bit_cnt = 0; shreg = '0;
      end
      if (!prev_sync && dac.sync_n) begin
        rise_cyc = cyc; low_len = cyc - fall_cyc;
        if (bit_cnt == 16) begin
          last_frame = shreg;
          frame_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL frame_sb: got %0h expected none queued", shreg);
          end else begin
            check("frame_sb", {16'd0, shreg}, {16'd0, exp_q.pop_front()});
          end
        end
      end
      if (!dac.sync_n && prev_sclk && !dac.sclk) begin
        shreg = {shreg[14:0], dac.din};
        bit_cnt++;
      end
      if (dac.done) done_cnt++;
      if (dac.overrun) ov_cnt++;
      prev_sync = dac.sync_n;
      prev_sclk = dac.sclk;
    end else begin
      prev_sync = 1; prev_sclk = 1; bit_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  int rx_cyc = 0;

  task automatic send(input logic [CB-1:0] v);
    @(posedge clk); #1;
    dac.rx = 1'b1; dac.y = v; rx_cyc = cyc;
    @(posedge clk); #1;
    dac.rx = 1'b0;
  endtask

  task automatic expect_frame(input string name, input logic [15:0] exp);
    int start, k;
    start = frame_cnt; k = 0;
    while (frame_cnt == start && k < 400) begin @(posedge clk); k++; end
    if (frame_cnt == start) begin
      n_vec++; n_miss++;
      $display("FAIL %s: got no frame expected %0h", name, exp);
    end else begin
      check(name, {16'd0, last_frame}, {16'd0, exp});
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin @(negedge clk); #1; k++; end
    while ((dac.busy || m_pend_v) && k < 400);
    if (dac.busy || m_pend_v) begin
      n_vec++; n_miss++;
      $display("FAIL wait_idle: got busy=%0b expected 0", dac.busy);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_miss++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int ov0, done0, fc0, k;
    dac.rx = 1'b0;
    dac.y  = '0;

    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {26'd0, dac.sclk, dac.sync_n, dac.din, dac.busy, dac.done, dac.overrun},
          32'b110000);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle_outputs", {26'd0, dac.sclk, dac.sync_n, dac.din, dac.busy, dac.done, dac.overrun},
          32'b110000);

    // y = 0 from idle: latency, frame, sync_n low length, one done
    done0 = done_cnt;
    send(25'h0000000);
    expect_frame("zero_frame", 16'h0800);
    check("latency", fall_cyc - rx_cyc, 2);
    check("sync_low_len", low_len, 64);
    check("done_count", done_cnt - done0, 1);

    // code table
    wait_idle(); send(25'h0004000); expect_frame("plus_half", 16'h0C00);
    wait_idle(); send(25'h1FF8000); expect_frame("minus_one", 16'h0000);
    wait_idle(); send(25'h0008000);
`ifdef DAC_SAT_EN
    expect_frame("plus_one", 16'h0FFF);
`else
    expect_frame("plus_one", 16'h0000);
`endif
    wait_idle(); send(25'h1FF6000);
`ifdef DAC_SAT_EN
    expect_frame("minus_1p25", 16'h0000);
`else
    expect_frame("minus_1p25", 16'h0E00);
`endif

    // two strobes during one frame: one overrun, first pending value lost
    wait_idle();
    send(25'h0002000);
    repeat (10) @(posedge clk);
    ov0 = ov_cnt;
    send(25'h1FFC000);
    repeat (5) @(posedge clk);
    send(25'h0006000);
    expect_frame("ovr_first", 16'h0A00);
    expect_frame("ovr_second", 16'h0E00);
    check("ovr_count", ov_cnt - ov0, 1);
    check("gap_len", gap_len, D);

    // strobe in the same cycle as the gap -> shift load: no overrun
    wait_idle();
    ov0 = ov_cnt;
    send(25'h0001000);
    repeat (5) @(posedge clk);
    send(25'h1FFE000);
    k = 0;
    do begin @(negedge clk); #1; k++; end while (!dac.done && k < 200);
    repeat (D - 1) @(posedge clk);
    #1; dac.rx = 1'b1; dac.y = 25'h1FFA000;
    @(posedge clk); #1; dac.rx = 1'b0;
    check("coinc_frame_a", {16'd0, last_frame}, 32'h0900);
    expect_frame("coinc_frame_b", 16'h0600);
    expect_frame("coinc_frame_c", 16'h0200);
    check("coinc_no_ovr", ov_cnt - ov0, 0);

    // reset in the middle of bit 7
    wait_idle();
    send(25'h0003000);
    k = 0;
    do begin @(negedge clk); #1; k++; end while (dac.sync_n && k < 20);
    repeat (33) @(posedge clk);
    #1;
    done0 = done_cnt; fc0 = frame_cnt;
    rst = 1'b0;
    #1;
    check("midreset_outputs", {26'd0, dac.sclk, dac.sync_n, dac.din, dac.busy, dac.done, dac.overrun},
          32'b110000);
    repeat (3) @(posedge clk); #2;
    rst = 1'b1;
    repeat (80) @(posedge clk);
    check("midreset_no_done", done_cnt - done0, 0);
    check("midreset_no_frame", frame_cnt - fc0, 0);
    send(25'h1FFF000);
    expect_frame("post_reset_frame", 16'h0700);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [CB-1:0] v;
      int gap;
      gap = $urandom_range(0, 80);
      repeat (gap) @(posedge clk);
      if ($urandom_range(0, 3) == 0) v = CB'($urandom);
      else                           v = CB'(int'($urandom_range(0, 65535)) - 32768);
      send(v);
    end
    wait_idle();
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dac_serial_out.md
# dac_serial_out

Downstream output stage of the filter chain: captures each filtered sample `y` when the filter's ready strobe (`rx_2`) pulses, converts the signed fixed-point word to a 12-bit offset-binary DAC code, and shifts it out MSB-first on a 3-wire serial DAC link (`sclk`, `sync_n`, `din`). A one-deep pending buffer decouples the filter's sample rate from the serial frame time, and an overrun flag reports dropped samples.

## Interface
- `cant_bits`, 25: width of input sample, signed two's complement.
- `frac_bits`, 15: fractional bits of input (Q9.15); ±1.0 is DAC full scale.
- `clk_div`, 2: `sclk` half-period in `clk` cycles (≥1).
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `rx` input 1: one-cycle strobe, `y` valid (driven by the filter's `rx_2`).
- `y` input `cant_bits`: filtered sample.
- `sclk` output 1: serial clock to DAC; idles high.
- `sync_n` output 1: frame enable, active-low.
- `din` output 1: serial data, MSB first.
- `busy` output 1: frame in progress (SHIFT or GAP).
- `done` output 1: one-cycle pulse at end of each frame.
- `overrun` output 1: one-cycle pulse when a pending sample is overwritten.

## Operation
- Conversion: `s = y >>> (frac_bits-11)` (arithmetic); saturate `s` to [-2048, 2047]; code = `s + 2048` (invert MSB). Computed combinationally from `y`, registered into pending buffer on `rx`.
- Frame: 16 bits = 4'b0000 control bits, then code[11:0], MSB first.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if pending valid -> SHIFT; load shift register with frame, clear pending valid, `sync_n`=0.
  - SHIFT: bit counter 15..0; each bit lasts `2*clk_div` cycles: `sclk` high `clk_div` cycles, then low `clk_div` cycles; `din` changes only at bit start (sclk rising); DAC samples on falling edge. After bit 0 low phase -> GAP, `sync_n`=1, `sclk`=1, `done` pulses.
  - GAP: hold `sync_n` high `clk_div` cycles, then -> SHIFT directly if pending valid (load as in IDLE), else IDLE.
- Pending buffer: `rx` writes code and sets valid. If valid already set and not consumed this cycle -> overwrite with new code, pulse `overrun`. If `rx` coincides with consumption (load) -> new code stored, valid stays set, no overrun.
- `rx` during SHIFT/GAP never disturbs the frame in flight.

## Timing
- Reset values: `sclk`=1, `sync_n`=1, `din`=0, `busy`=0, `done`=0, `overrun`=0, pending valid=0, state IDLE.
- `rx` at edge k -> pending valid after edge k; `sync_n` falls and first bit on `din` after edge k+1 (latency 2 cycles from idle).
- Frame: `32*clk_div` cycles with `sync_n` low; then `clk_div` GAP cycles. Default: 64 + 2 = 66 cycles minimum sample period.
- `done` asserted the cycle state enters GAP; `busy` high from SHIFT entry through last GAP cycle.
- Reset asserted mid-frame: all outputs return immediately to reset values; frame and pending sample discarded; no `done`.

## Configuration
- `DAC_SAT_EN` defined: saturation as above (1.0 -> 0xFFF, -1.25 -> 0x000).
- Not defined: no saturation; code = low 12 bits of `s` with MSB inverted (wraps: 1.0 -> 0x000). Saves comparators; used when the filter output is known bounded.

## Structure
- Shared package: frame width (16), DAC code width (12), control nibble 4'b0000, FSM state encodings.
- One sub-module: `sat_conv` (fixed-point to offset-binary conversion, `DAC_SAT_EN` handling); FSM, counters, pending buffer and shift register in the top.

## Test plan
- `rx` with `y`=0 from idle -> `sync_n` falls 2 cycles later; 16 bits shifted = 0x0800; `done` after 64 cycles of `sync_n` low.
- `y`=0x004000 (+0.5) -> frame 0x0C00; `y`=0x1FF8000 (-1.0) -> 0x0000, checked on `sclk` falling edges.
- `y`=0x0008000 (+1.0): with `DAC_SAT_EN` -> 0x0FFF; without -> 0x0000.
- Two `rx` strobes during one frame -> one `overrun` pulse, second value sent in next frame directly after 2-cycle GAP, first pending value never sent.
- `rx` in the cycle of GAP->SHIFT load -> no `overrun`; new sample sent in following frame.
- Deassert-assert `rst` at bit 7 of a frame -> `sync_n`=1, `sclk`=1, `din`=0 immediately; no `done`; next `rx` produces a clean full frame.
